// File: rtl/bitslip_align.sv
// rtl/bitslip_align.sv - per-channel barrel realigner with training FSM for deserialised ADC lanes
module bitslip_align #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int MATCH_COUNT   = 16,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                              clk_div,
  input  logic                              reset,
  input  logic                              ena,
  input  logic [CHANNELS*WIDTH-1:0]         data_in,
  input  logic [WIDTH-1:0]                  train_pattern,
  input  logic                              train_start,
  input  logic                              manual_mode,
  input  logic [CHANNELS*$clog2(WIDTH)-1:0] manual_count,
  output logic [CHANNELS*WIDTH-1:0]         data_out,
  output logic [CHANNELS*$clog2(WIDTH)-1:0] slip_count,
  output logic [CHANNELS-1:0]               locked,
  output logic                              train_busy,
  output logic                              train_fail
);
  localparam int SLIP_W = $clog2(WIDTH);
  localparam int MC_W   = $clog2(MATCH_COUNT + 1);
  localparam int ST_W   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, LOCKED, FAIL} state_t;

  logic [CHANNELS-1:0] busy_r;
  logic [CHANNELS-1:0] fail_r;

  assign train_busy = |busy_r;
  assign train_fail = |fail_r;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0]  stage_one;
    logic [WIDTH-1:0]  stage_two;
    logic [WIDTH-1:0]  dout;
    logic [WIDTH-1:0]  aligned;
    logic [SLIP_W-1:0] slip;
    logic [MC_W-1:0]   match_cnt;
    logic [ST_W-1:0]   settle_cnt;
    logic              lock;
    state_t            state;

    // Low WIDTH bits of {newer, older} >> s = {stage_one[s-1:0], stage_two[WIDTH-1:s]}
    assign aligned = WIDTH'({stage_one, stage_two} >> slip);

    assign data_out[c*WIDTH +: WIDTH]    = dout;
    assign slip_count[c*SLIP_W +: SLIP_W] = slip;
    assign locked[c]                      = lock;

    always_ff @(posedge clk_div) begin
      if (reset) begin
        stage_one <= '0;
        stage_two <= '0;
        dout      <= '0;
      end else if (ena) begin
        stage_one <= data_in[c*WIDTH +: WIDTH];
        stage_two <= stage_one;
        dout      <= aligned;
      end
    end

    always_ff @(posedge clk_div) begin
      if (reset) begin
        state      <= IDLE;
        slip       <= '0;
        match_cnt  <= '0;
        settle_cnt <= '0;
        lock       <= 1'b0;
        busy_r[c]  <= 1'b0;
        fail_r[c]  <= 1'b0;
      end else if (ena) begin
        if (manual_mode) begin
          state      <= IDLE;
          slip       <= manual_count[c*SLIP_W +: SLIP_W];
          match_cnt  <= '0;
          settle_cnt <= '0;
          lock       <= 1'b0;
          busy_r[c]  <= 1'b0;
          fail_r[c]  <= 1'b0;
        end else if (train_start) begin
          state      <= SETTLE;
          slip       <= '0;
          match_cnt  <= '0;
          settle_cnt <= ST_W'(SETTLE_CYCLES);
          lock       <= 1'b0;
          busy_r[c]  <= 1'b1;
          fail_r[c]  <= 1'b0;
        end else begin
          case (state)
            SETTLE: begin
              settle_cnt <= settle_cnt - ST_W'(1);
              if (settle_cnt == ST_W'(1)) state <= CHECK;
            end
            CHECK: begin
              if (dout == train_pattern) begin
                match_cnt <= match_cnt + MC_W'(1);
                if (match_cnt == MC_W'(MATCH_COUNT - 1)) begin
                  lock      <= 1'b1;
                  state     <= LOCKED;
                  busy_r[c] <= 1'b0;
                end
              end else if (slip == SLIP_W'(WIDTH - 1)) begin
                slip      <= '0;
                state     <= FAIL;
                busy_r[c] <= 1'b0;
                fail_r[c] <= 1'b1;
              end else begin
                slip       <= slip + SLIP_W'(1);
                match_cnt  <= '0;
                settle_cnt <= ST_W'(SETTLE_CYCLES);
                state      <= SETTLE;
              end
            end
            FAIL:    lock <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bitslip_align.sv
// tb/tb_bitslip_align.sv - randomized self-checking bench for bitslip_align against a timing-formula model
module tb_bitslip_align;
  localparam int W  = 8;
  localparam int CH = 2;
  localparam int MC = 4;
  localparam int SC = 3;
  localparam int SW = 3;

  logic            clk_div = 1'b0;
  logic            reset;
  logic            ena;
  logic [CH*W-1:0] data_in;
  logic [W-1:0]    train_pattern;
  logic            train_start;
  logic            manual_mode;
  logic [CH*SW-1:0] manual_count;
  logic [CH*W-1:0] data_out;
  logic [CH*SW-1:0] slip_count;
  logic [CH-1:0]   locked;
  logic            train_busy;
  logic            train_fail;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] d [CH];

  bitslip_align #(.WIDTH(W), .CHANNELS(CH), .MATCH_COUNT(MC), .SETTLE_CYCLES(SC)) dut (
    .clk_div(clk_div), .reset(reset), .ena(ena), .data_in(data_in),
    .train_pattern(train_pattern), .train_start(train_start),
    .manual_mode(manual_mode), .manual_count(manual_count),
    .data_out(data_out), .slip_count(slip_count), .locked(locked),
    .train_busy(train_busy), .train_fail(train_fail)
  );

  always #5 clk_div = ~clk_div;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int s);
    int x;
    x = int'(v);
    return W'(((x >> s) | (x << (W - s))) & ((1 << W) - 1));
  endfunction

  function automatic int find_slip(input logic [W-1:0] v, input logic [W-1:0] pat);
    for (int s = 0; s < W; s++)
      if (ror(v, s) == pat) return s;
    return -1;
  endfunction

  task automatic set_data();
    for (int c = 0; c < CH; c++) data_in[c*W +: W] = d[c];
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_div);
      #1;
    end
  endtask

  function automatic int dout(input int c);
    return int'(data_out[c*W +: W]);
  endfunction

  function automatic int slip(input int c);
    return int'(slip_count[c*SW +: SW]);
  endfunction

  // Predicts every output from the number k of enabled edges since train_start:
  // each rejected slip costs SETTLE+1 edges, the winning slip SETTLE+MATCH edges.
  task automatic run_train(input int ena_div, input int abort_k);
    int s [CH];
    int done_k [CH];
    int k, max_k, cyc, es;
    bit eb, ef;
    max_k = 0;
    for (int c = 0; c < CH; c++) begin
      s[c] = find_slip(d[c], train_pattern);
      done_k[c] = (s[c] >= 0) ? 1 + s[c]*(SC+1) + SC + MC : 1 + W*(SC+1);
      if (done_k[c] + 3 > max_k) max_k = done_k[c] + 3;
    end
    if (abort_k > 0) max_k = abort_k;
    k = 0;
    cyc = 0;
    while (k < max_k && cyc < 2000) begin
      ena = (cyc % ena_div == 0);
      train_start = (k == 0) && ena;
      @(posedge clk_div);
      #1;
      if (ena) k++;
      train_start = 1'b0;
      eb = 1'b0;
      ef = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (s[c] >= 0) begin
          es = (k - 1) / (SC + 1);
          if (es > s[c]) es = s[c];
        end else begin
          es = (k >= done_k[c]) ? 0 : (k - 1) / (SC + 1);
          if (k >= done_k[c]) ef = 1'b1;
        end
        if (k < done_k[c]) eb = 1'b1;
        check($sformatf("slip%0d k=%0d", c, k), slip(c), es);
        check($sformatf("locked%0d k=%0d", c, k), locked[c], (s[c] >= 0) && (k >= done_k[c]));
      end
      check($sformatf("busy k=%0d", k), train_busy, eb);
      check($sformatf("fail k=%0d", k), train_fail, ef);
      cyc++;
    end
    ena = 1'b1;
    if (k < max_k) check("train_budget", k, max_k);
    if (abort_k == 0)
      for (int c = 0; c < CH; c++)
        check($sformatf("dout_final%0d", c), dout(c), ror(d[c], (s[c] >= 0) ? s[c] : 0));
  endtask

  initial begin
    reset = 1'b1; ena = 1'b1; train_start = 1'b0; manual_mode = 1'b0;
    manual_count = '0; train_pattern = 8'h0F; data_in = '0;
    step(2);
    reset = 1'b0;
    check("rst_dout", data_out, 0);
    check("rst_slip", slip_count, 0);
    check("rst_locked", locked, 0);
    check("rst_busy", train_busy, 0);
    check("rst_fail", train_fail, 0);

    d[0] = 8'h78; d[1] = 8'h0F; set_data(); step(4);
    run_train(1, 0);

    d[0] = 8'h55; set_data(); step(4);
    run_train(1, 0);

    d[0] = 8'h78; set_data(); step(4);
    run_train(3, 0);

    // Lock survives a data change (no monitoring); retrain finds the new slip
    d[0] = 8'h3C; set_data(); step(6);
    check("hold_locked", locked[0], 1);
    check("hold_slip", slip(0), 3);
    check("hold_dout", dout(0), ror(8'h3C, 3));
    run_train(1, 0);

    // Reset mid-SETTLE
    d[0] = 8'h78; d[1] = 8'h0F; set_data(); step(4);
    run_train(1, 2);
    reset = 1'b1; step(1); reset = 1'b0;
    check("mrst_dout", data_out, 0);
    check("mrst_slip", slip_count, 0);
    check("mrst_locked", locked, 0);
    check("mrst_busy", train_busy, 0);
    check("mrst_fail", train_fail, 0);
    step(2);
    check("mrst_idle", train_busy, 0);

    // Restart mid-CHECK (ch1 matching at slip 0, ch0 at slip 1)
    step(4);
    run_train(1, 6);
    run_train(1, 0);

    for (int r = 0; r < 6; r++) begin
      train_pattern = W'($urandom);
      for (int c = 0; c < CH; c++)
        d[c] = ($urandom_range(0, 2) != 0) ? ror(train_pattern, W - $urandom_range(0, W-1)) : W'($urandom);
      set_data(); step(4);
      run_train(($urandom_range(0, 1) == 1) ? 2 : 1, 0);
    end

    // Manual mode beats train_start
    manual_mode = 1'b1;
    manual_count = {3'd2, 3'd5};
    d[0] = 8'hA1; d[1] = 8'hC3; set_data();
    train_start = 1'b1; step(1); train_start = 1'b0; step(3);
    check("man_dout0", dout(0), 8'h0D);
    check("man_dout1", dout(1), ror(8'hC3, 2));
    check("man_slip0", slip(0), 5);
    check("man_locked", locked, 0);
    check("man_busy", train_busy, 0);

    // Three-edge latency at slip 0
    manual_count = '0;
    d[0] = 8'h12; d[1] = 8'h34; set_data(); step(4);
    d[0] = 8'hE7; d[1] = 8'h9B; set_data(); step(2);
    check("lat_old0", dout(0), 8'h12);
    check("lat_old1", dout(1), 8'h34);
    step(1);
    check("lat_new0", dout(0), 8'hE7);
    check("lat_new1", dout(1), 8'h9B);

    // Leaving manual keeps the last slip
    manual_count = {3'd1, 3'd6}; step(1);
    manual_mode = 1'b0; manual_count = '0; step(3);
    check("keep_slip0", slip(0), 6);
    check("keep_slip1", slip(1), 1);
    check("keep_busy", train_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
